clock_disp_ctrl: RTL and testbench
==================================

// Module: clock_disp_ctrl
// PURPOSE
//  MM:SS time-keeping and set-mode controller for the 4-digit seven-segment display path.
//  Keeps a BCD minutes:seconds count and runs a RUN/SET_MIN/SET_SEC mode FSM driven by two keys.
//  Drives the 16-bit BCD disp_num word consumed by the seg scan driver: [15:12]=min tens ... [3:0]=sec units.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per second tick; must be >=2; benches use 4
//  CNT_W      26          prescaler width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  rst        in   1   asynchronous, active-low reset
//  key_mode   in   1   single-cycle pulse, synchronous to clk, already debounced
//  key_inc    in   1   single-cycle pulse, synchronous to clk, already debounced
//  disp_num   out  16  BCD {min_hi,min_lo,sec_hi,sec_lo}; driven directly from the counter registers
//  mode       out  2   00=RUN, 01=SET_MIN, 10=SET_SEC
//  sec_tick   out  1   one-cycle pulse on every prescaler terminal count in RUN
//  wrap       out  1   one-cycle pulse, same cycle as the 59:59->00:00 update in RUN
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - prescaler=0, all digits=0, state=RUN.
//   - disp_num=16'h0000, mode=00, sec_tick=0, wrap=0.
//  Prescaler:
//   - Counts 0..TICK_DIV-1, but only in RUN; it holds its value in either SET state.
//   - At terminal count it returns to 0, and sec_tick=1 on the next cycle.
//   - It clears to 0 on the SET_SEC->RUN transition, so the first second after setting is a full period.
//  RUN: on each tick the seconds count increments.
//   - sec_lo 9->0 carries into sec_hi; sec_hi 5->0 carries into min_lo.
//   - min_lo 9->0 carries into min_hi; min_hi 5->0 completes the wrap.
//   - 59:59 -> 00:00 pulses wrap in the same cycle that disp_num shows 16'h0000.
//   - key_inc is ignored in RUN.
//  FSM transitions, taken on key_mode:
//   - RUN -> SET_MIN -> SET_SEC -> RUN.
//   - Mode changes never alter the digit values.
//   - Encoding 11 is illegal; it forces RUN on the next clk.
//  SET_MIN: key_inc adds 1 to the minutes, BCD mod 60 (59->00). Seconds are unaffected.
//  SET_SEC: key_inc adds 1 to the seconds, BCD mod 60 (59->00), with no carry into the minutes.
//  Simultaneous key_mode and key_inc: key_mode wins and that key_inc is dropped.
//  Latency: any digit update is visible on disp_num one clk after the causing edge (registered counters, no extra stage).
//  Invariant: digits never take non-BCD values (sec_hi/min_hi <=5, lo <=9). Every state reachable after reset satisfies it.
//  Reset mid-count or mid-set returns immediately to 00:00 RUN; pending key pulses are lost.
// CONFIGURATION
//  ALARM_EN defined:
//   - Adds input al_time[15:0] (BCD MMSS) and output alarm (1 bit, reset value 0).
//   - alarm pulses for one clk when, in RUN, a tick update makes the counter equal al_time.
//   - It is asserted in the same cycle disp_num first shows that value.
//   - Setting the counter to al_time in a SET state does not fire alarm.
//  ALARM_EN undefined: neither port exists and no compare logic is built.
// TESTING (TICK_DIV=4)
//  1. Reset:
//     - Release rst and run 4 clks -> sec_tick pulses, disp_num=16'h0001, mode=00.
//  2. Carry chain:
//     - Preload 09:59 via set mode, then return to RUN and wait 1 tick -> disp_num=16'h1000, wrap=0.
//     - From 59:59, wait 1 tick -> disp_num=16'h0000, wrap=1 for 1 clk.
//  3. Set mode:
//     - key_mode, then key_inc x61 -> mode=01, disp_num minutes=01, seconds unchanged.
//     - key_mode, then key_inc x60 -> mode=10, seconds unchanged (mod 60), minutes unchanged.
//  4. Collision:
//     - In SET_MIN, assert key_mode and key_inc in the same clk -> mode=10, minutes unchanged.
//     - With the prescaler frozen, sec_tick must stay 0 throughout the SET states.
//  5. Reset mid-set:
//     - In SET_SEC at 12:34, drop rst -> disp_num=0000 and mode=00 immediately.
//  6. ALARM_EN build:
//     - al_time=16'h0003, run from reset -> alarm=1 on the 3rd tick only.
//     - Setting 00:03 manually -> no alarm.

Source files
------------

// File: rtl/clock_disp_ctrl.sv
// MM:SS BCD time-keeper with a RUN / SET_MIN / SET_SEC mode FSM driven by two debounced keys.
// Optional alarm compare is built only when the ALARM_EN macro is defined.
module clock_disp_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
`ifdef ALARM_EN
  input  logic [15:0] al_time,
  output logic        alarm,
`endif
  output logic [15:0] disp_num,
  output logic [1:0]  mode,
  output logic        sec_tick,
  output logic        wrap
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_SET_MIN = 2'b01;
  localparam logic [1:0] ST_SET_SEC = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sec_q, sec_d;
  logic [7:0]       min_q, min_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic [8:0]       sec_nx, min_nx;
  logic             tick;

  // Two-digit BCD increment modulo 60; bit 8 is the carry out of 59->00.
  function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
    logic [8:0] r;
    r = {1'b0, v};
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] >= 4'd5) begin
        r[7:4] = 4'd0;
        r[8]   = 1'b1;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  assign sec_nx = bcd_inc60(sec_q);
  assign min_nx = bcd_inc60(min_q);
  assign tick   = (state_q == ST_RUN) && (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    sec_d   = sec_q;
    min_d   = min_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          tick_d = 1'b1;
          sec_d  = sec_nx[7:0];
          if (sec_nx[8]) begin
            min_d  = min_nx[7:0];
            wrap_d = min_nx[8];
          end
        end
        if (key_mode) state_d = ST_SET_MIN;
      end
      ST_SET_MIN: begin
        if (key_mode)     state_d = ST_SET_SEC;
        else if (key_inc) min_d   = min_nx[7:0];
      end
      ST_SET_SEC: begin
        // Restart the prescaler so the first second after setting is a full period.
        if (key_mode) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (key_inc) begin
          sec_d = sec_nx[7:0];
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef ALARM_EN
  logic alarm_q, alarm_d;

  // Only a tick update can fire the alarm; manual setting never does.
  always_comb begin
    alarm_d = tick && ({min_d, sec_d} == al_time);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alarm_q <= 1'b0;
    else      alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

  assign disp_num = {min_q, sec_q};
  assign mode     = state_q;
  assign sec_tick = tick_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_clock_disp_ctrl.sv
// Directed bench for clock_disp_ctrl with TICK_DIV=4; alarm checks are compiled in when ALARM_EN is defined.
module tb_clock_disp_ctrl;

  logic        clk;
  logic        rst;
  logic        key_mode;
  logic        key_inc;
  logic [15:0] disp_num;
  logic [1:0]  mode;
  logic        sec_tick;
  logic        wrap;
`ifdef ALARM_EN
  logic [15:0] al_time;
  logic        alarm;
`endif

  int n_cmp;
  int n_err;
  logic tick_seen;

  clock_disp_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_mode (key_mode),
    .key_inc  (key_inc),
`ifdef ALARM_EN
    .al_time  (al_time),
    .alarm    (alarm),
`endif
    .disp_num (disp_num),
    .mode     (mode),
    .sec_tick (sec_tick),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    key_mode = 1'b1;
    @(negedge clk);
    key_mode = 1'b0;
    tick_seen |= sec_tick;
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      key_inc = 1'b1;
      @(negedge clk);
      tick_seen |= sec_tick;
      key_inc = 1'b0;
      @(negedge clk);
      tick_seen |= sec_tick;
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    tick_seen = 1'b0;
    rst       = 1'b0;
    key_mode  = 1'b0;
    key_inc   = 1'b0;
`ifdef ALARM_EN
    al_time   = 16'h0003;
`endif

    // Reset state
    step(2);
    check("rst_disp", 32'(disp_num), 32'h0000);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_tick", 32'(sec_tick), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
`ifdef ALARM_EN
    check("rst_alarm", 32'(alarm), 32'h0);
`endif

    // First second: tick after the 4th edge
    rst = 1'b1;
    step(3);
    check("pre_tick_disp", 32'(disp_num), 32'h0000);
    check("pre_tick_flag", 32'(sec_tick), 32'h0);
    step(1);
    check("first_tick_flag", 32'(sec_tick), 32'h1);
    check("first_tick_disp", 32'(disp_num), 32'h0001);
    check("first_tick_mode", 32'(mode), 32'h0);
    step(1);
    check("tick_one_cycle", 32'(sec_tick), 32'h0);

    // Set mode: minutes mod 60, seconds mod 60, no tick while frozen
    tick_seen = 1'b0;
    press_mode();
    check("enter_setmin_mode", 32'(mode), 32'h1);
    check("enter_setmin_disp", 32'(disp_num), 32'h0001);
    press_inc(61);
    check("setmin61_mode", 32'(mode), 32'h1);
    check("setmin61_disp", 32'(disp_num), 32'h0101);
    press_mode();
    check("enter_setsec_mode", 32'(mode), 32'h2);
    press_inc(60);
    check("setsec60_mode", 32'(mode), 32'h2);
    check("setsec60_disp", 32'(disp_num), 32'h0101);
    check("no_tick_in_set", 32'(tick_seen), 32'h0);

    // Collision in SET_MIN: key_mode wins
    press_mode();
    press_mode();
    check("collide_pre_mode", 32'(mode), 32'h1);
    key_mode = 1'b1;
    key_inc  = 1'b1;
    @(negedge clk);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    check("collide_mode", 32'(mode), 32'h2);
    check("collide_disp", 32'(disp_num), 32'h0101);

    // Carry chain 09:59 -> 10:00
    press_mode();
    press_mode();
    press_inc(8);
    press_mode();
    press_inc(58);
    check("preload_0959", 32'(disp_num), 32'h0959);
    press_mode();
    check("back_to_run", 32'(mode), 32'h0);
    step(3);
    check("hold_0959", 32'(disp_num), 32'h0959);
    step(1);
    check("carry_1000_disp", 32'(disp_num), 32'h1000);
    check("carry_1000_wrap", 32'(wrap), 32'h0);
    check("carry_1000_tick", 32'(sec_tick), 32'h1);

    // Wrap 59:59 -> 00:00
    press_mode();
    press_inc(49);
    press_mode();
    press_inc(59);
    check("preload_5959", 32'(disp_num), 32'h5959);
    press_mode();
    step(3);
    check("pre_wrap_flag", 32'(wrap), 32'h0);
    step(1);
    check("wrap_disp", 32'(disp_num), 32'h0000);
    check("wrap_flag", 32'(wrap), 32'h1);
    step(1);
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // key_inc ignored in RUN
    key_inc = 1'b1;
    @(negedge clk);
    key_inc = 1'b0;
    check("run_inc_ignored", 32'(disp_num), 32'h0000);
    step(2);
    check("run_next_tick", 32'(disp_num), 32'h0001);

    // Reset mid-set at 12:34
    press_mode();
    press_inc(12);
    press_mode();
    press_inc(33);
    check("preload_1234", 32'(disp_num), 32'h1234);
    check("preload_mode", 32'(mode), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_disp", 32'(disp_num), 32'h0000);
    check("async_rst_mode", 32'(mode), 32'h0);
    step(1);
    rst = 1'b1;

`ifdef ALARM_EN
    // Alarm on the 3rd tick only, not on manual setting
    step(4);
    check("al_tick1_disp", 32'(disp_num), 32'h0001);
    check("al_tick1", 32'(alarm), 32'h0);
    step(4);
    check("al_tick2", 32'(alarm), 32'h0);
    step(4);
    check("al_tick3_disp", 32'(disp_num), 32'h0003);
    check("al_tick3", 32'(alarm), 32'h1);
    step(1);
    check("al_one_cycle", 32'(alarm), 32'h0);
    press_mode();
    press_mode();
    press_inc(59);
    check("al_set_0002", 32'(disp_num), 32'h0002);
    key_inc = 1'b1;
    @(negedge clk);
    key_inc = 1'b0;
    check("al_set_0003_disp", 32'(disp_num), 32'h0003);
    check("al_set_no_alarm", 32'(alarm), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
